// File: rtl/coprocessor0_timer_intr_if.sv
// CP0 <-> pipeline bundle: mtc0 writes, exception/eret commits, interrupt lines and read/status returns.
interface coprocessor0_timer_intr_if #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned HW_INT_COUNT = 6
);
    logic                    write_enabled;
    logic [4:0]              address_register;
    logic [2:0]              address_select;
    logic [DATA_WIDTH-1:0]   write_data;
    logic                    exception_valid;
    logic [4:0]              exception_code;
    logic [DATA_WIDTH-1:0]   exception_address;
    logic [DATA_WIDTH-1:0]   bad_virtual_address;
    logic                    in_delay_slot;
    logic                    eret_flush;
    logic [HW_INT_COUNT-1:0] hardware_interrupt;
    logic [DATA_WIDTH-1:0]   read_data;
    logic [DATA_WIDTH-1:0]   epc_out;
    logic                    exception_level_out;
    logic                    interrupt_pending;

    modport master (
        output write_enabled, address_register, address_select, write_data,
        output exception_valid, exception_code, exception_address, bad_virtual_address,
        output in_delay_slot, eret_flush, hardware_interrupt,
        input  read_data, epc_out, exception_level_out, interrupt_pending
    );

    modport slave (
        input  write_enabled, address_register, address_select, write_data,
        input  exception_valid, exception_code, exception_address, bad_virtual_address,
        input  in_delay_slot, eret_flush, hardware_interrupt,
        output read_data, epc_out, exception_level_out, interrupt_pending
    );
endinterface

// File: rtl/coprocessor0_timer_intr.sv
// CP0 with Status/Cause/EPC/BadVAddr, interrupt sampling and an optional prescaled Count/Compare timer.
// Timer logic is built only when CP0_TIMER_EN is defined.
module coprocessor0_timer_intr #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned HW_INT_COUNT  = 6,
    parameter int unsigned COUNT_DIVIDER = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    coprocessor0_timer_intr_if.slave bus
);
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam int unsigned PRESCALE_W  = (COUNT_DIVIDER > 1) ? $clog2(COUNT_DIVIDER) : 1;

    logic                    sel0;
    logic                    wr_sel0;
    logic                    wr_status;
    logic                    wr_cause;
    logic                    wr_epc;
    logic [7:0]              status_im;
    logic                    status_exl;
    logic                    status_ie;
    logic                    cause_bd;
    logic                    cause_ti;
    logic [HW_INT_COUNT-1:0] cause_hw;
    logic [1:0]              cause_sw;
    logic [4:0]              cause_exc;
    logic [7:0]              cause_ip;
    logic [DATA_WIDTH-1:0]   epc;
    logic [DATA_WIDTH-1:0]   bad_vaddr;
    logic [DATA_WIDTH-1:0]   count_value;
    logic [DATA_WIDTH-1:0]   compare_value;
    logic [DATA_WIDTH-1:0]   status_value;
    logic [DATA_WIDTH-1:0]   cause_value;

    assign sel0      = (bus.address_select == 3'd0);
    assign wr_sel0   = bus.write_enabled && sel0;
    assign wr_status = wr_sel0 && (bus.address_register == REG_STATUS);
    assign wr_cause  = wr_sel0 && (bus.address_register == REG_CAUSE);
    assign wr_epc    = wr_sel0 && (bus.address_register == REG_EPC);

    // Status: IM/IE from mtc0; EXL priority exception > eret > mtc0.
    always_ff @(posedge clock) begin
        if (reset) begin
            status_im  <= 8'd0;
            status_exl <= 1'b0;
            status_ie  <= 1'b0;
        end else begin
            if (wr_status) begin
                status_im <= bus.write_data[15:8];
                status_ie <= bus.write_data[0];
            end
            if (bus.exception_valid)  status_exl <= 1'b1;
            else if (bus.eret_flush)  status_exl <= 1'b0;
            else if (wr_status)       status_exl <= bus.write_data[1];
        end
    end

    // Cause (except TI), EPC and BadVAddr updates from exception commits and mtc0.
    always_ff @(posedge clock) begin
        if (reset) begin
            cause_bd  <= 1'b0;
            cause_hw  <= '0;
            cause_sw  <= 2'd0;
            cause_exc <= 5'd0;
            epc       <= '0;
            bad_vaddr <= '0;
        end else begin
            cause_hw <= bus.hardware_interrupt;
            if (wr_cause) cause_sw <= bus.write_data[1:0];
            if (bus.exception_valid) begin
                cause_exc <= bus.exception_code;
                if (!status_exl) cause_bd <= bus.in_delay_slot;
            end
            if (bus.exception_valid && !status_exl)
                epc <= bus.in_delay_slot ? bus.exception_address - DATA_WIDTH'(4)
                                         : bus.exception_address;
            else if (wr_epc)
                epc <= bus.write_data;
            if (bus.exception_valid && (bus.exception_code == 5'h04 || bus.exception_code == 5'h05))
                bad_vaddr <= bus.bad_virtual_address;
        end
    end

`ifdef CP0_TIMER_EN
    logic                  wr_count;
    logic                  wr_compare;
    logic [DATA_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0] compare;
    logic [PRESCALE_W-1:0] prescaler;
    logic                  prescale_wrap;
    logic                  timer_match;

    assign wr_count      = wr_sel0 && (bus.address_register == REG_COUNT);
    assign wr_compare    = wr_sel0 && (bus.address_register == REG_COMPARE);
    assign prescale_wrap = (prescaler == PRESCALE_W'(COUNT_DIVIDER - 1));
    assign timer_match   = (count == compare) && !wr_count;
    assign count_value   = count;
    assign compare_value = compare;

    // Prescaled Count; TI is sticky until a Compare write, which beats a same-cycle match.
    always_ff @(posedge clock) begin
        if (reset) begin
            count     <= '0;
            compare   <= '0;
            prescaler <= '0;
            cause_ti  <= 1'b0;
        end else begin
            if (wr_count) begin
                count     <= bus.write_data;
                prescaler <= '0;
            end else if (prescale_wrap) begin
                count     <= count + DATA_WIDTH'(1);
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + PRESCALE_W'(1);
            end
            if (wr_compare) begin
                compare  <= bus.write_data;
                cause_ti <= 1'b0;
            end else if (timer_match) begin
                cause_ti <= 1'b1;
            end
        end
    end
`else
    assign cause_ti      = 1'b0;
    assign count_value   = '0;
    assign compare_value = '0;
`endif

    always_comb begin
        cause_ip                    = 8'd0;
        cause_ip[1:0]               = cause_sw;
        cause_ip[2 +: HW_INT_COUNT] = cause_hw;
        cause_ip[7]                 = cause_ip[7] | cause_ti;
    end

    always_comb begin
        status_value       = '0;
        status_value[22]   = 1'b1;
        status_value[15:8] = status_im;
        status_value[1]    = status_exl;
        status_value[0]    = status_ie;
        cause_value        = '0;
        cause_value[31]    = cause_bd;
        cause_value[30]    = cause_ti;
        cause_value[15:8]  = cause_ip;
        cause_value[6:2]   = cause_exc;
    end

    // mfc0 read: OR of one-hot gated register values; unmapped reads 0.
    always_comb begin
        bus.read_data =
              ({DATA_WIDTH{sel0 && bus.address_register == REG_BADVADDR}} & bad_vaddr)
            | ({DATA_WIDTH{sel0 && bus.address_register == REG_COUNT}}    & count_value)
            | ({DATA_WIDTH{sel0 && bus.address_register == REG_COMPARE}}  & compare_value)
            | ({DATA_WIDTH{sel0 && bus.address_register == REG_STATUS}}   & status_value)
            | ({DATA_WIDTH{sel0 && bus.address_register == REG_CAUSE}}    & cause_value)
            | ({DATA_WIDTH{sel0 && bus.address_register == REG_EPC}}      & epc);
    end

    assign bus.epc_out             = epc;
    assign bus.exception_level_out = status_exl;
    assign bus.interrupt_pending   = status_ie && !status_exl && |(cause_ip & status_im);
endmodule

// File: tb/tb_coprocessor0_timer_intr.sv
// Self-checking bench for coprocessor0_timer_intr: directed scenarios plus randomized traffic vs a reference model.
module tb_coprocessor0_timer_intr;
    localparam int unsigned DW  = 32;
    localparam int unsigned HW  = 6;
    localparam int unsigned DIV = 2;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    coprocessor0_timer_intr_if #(.DATA_WIDTH(DW), .HW_INT_COUNT(HW)) bus ();

    coprocessor0_timer_intr #(.DATA_WIDTH(DW), .HW_INT_COUNT(HW), .COUNT_DIVIDER(DIV)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // Architectural reference state; Count is held as load value plus elapsed cycles.
    logic [7:0]      m_im;
    logic            m_exl, m_ie, m_bd, m_ti;
    logic [HW-1:0]   m_hw;
    logic [1:0]      m_sw;
    logic [4:0]      m_exc;
    logic [31:0]     m_epc, m_bva, m_count_base, m_compare;
    longint unsigned m_ticks;

    function automatic logic [31:0] m_count();
`ifdef CP0_TIMER_EN
        return m_count_base + 32'(m_ticks / longint'(DIV));
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [7:0] m_ip();
        return {m_hw[5] | m_ti, m_hw[4:0], m_sw};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
        if (s != 3'd0) return 32'd0;
        case (a)
            5'd8:    return m_bva;
            5'd9:    return m_count();
            5'd11:   return m_compare;
            5'd12:   return {9'd0, 1'b1, 6'd0, m_im, 6'd0, m_exl, m_ie};
            5'd13:   return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_exc, 2'd0};
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_pending();
        return m_ie && !m_exl && (|(m_ip() & m_im));
    endfunction

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 6))
            0:       return 5'd8;
            1:       return 5'd9;
            2:       return 5'd11;
            3:       return 5'd12;
            4:       return 5'd13;
            5:       return 5'd14;
            default: return 5'($urandom);
        endcase
    endfunction

    // One clock edge: inputs are sampled before the edge, model advanced to match, then settle.
    task automatic tick();
        logic        wr;
        logic [4:0]  a;
        logic [31:0] wd;
        logic [31:0] cnt_now;
        logic        n_exl;
        wr      = bus.write_enabled && (bus.address_select == 3'd0);
        a       = bus.address_register;
        wd      = bus.write_data;
        cnt_now = m_count();
        @(posedge clock);
        if (reset) begin
            m_im = 8'd0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0; m_ti = 1'b0;
            m_hw = '0; m_sw = 2'd0; m_exc = 5'd0; m_epc = 32'd0; m_bva = 32'd0;
            m_count_base = 32'd0; m_compare = 32'd0; m_ticks = 0;
        end else begin
            n_exl = bus.exception_valid ? 1'b1 : bus.eret_flush ? 1'b0 : (wr && a == 5'd12) ? wd[1] : m_exl;
            if (wr && a == 5'd12) begin m_im = wd[15:8]; m_ie = wd[0]; end
            if (wr && a == 5'd13) m_sw = wd[1:0];
            m_hw = bus.hardware_interrupt;
            if (bus.exception_valid) begin
                m_exc = bus.exception_code;
                if (!m_exl) m_bd = bus.in_delay_slot;
                if (bus.exception_code == 5'h04 || bus.exception_code == 5'h05) m_bva = bus.bad_virtual_address;
            end
            if (bus.exception_valid && !m_exl)
                m_epc = bus.in_delay_slot ? bus.exception_address - 32'd4 : bus.exception_address;
            else if (wr && a == 5'd14)
                m_epc = wd;
`ifdef CP0_TIMER_EN
            if (wr && a == 5'd9) begin m_count_base = wd; m_ticks = 0; end
            else m_ticks = m_ticks + 1;
            if (wr && a == 5'd11) begin m_compare = wd; m_ti = 1'b0; end
            else if (cnt_now == m_compare && !(wr && a == 5'd9)) m_ti = 1'b1;
`endif
            m_exl = n_exl;
        end
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.write_enabled = 1'b1; bus.address_register = a; bus.address_select = 3'd0; bus.write_data = d;
        tick();
        bus.write_enabled = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        logic [4:0]  a;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin a = 5'd12; exp = 32'h0040_0000; end
                1: begin a = 5'd13; exp = 32'd0; end
                2: begin a = 5'd14; exp = 32'd0; end
                3: begin a = 5'd9;  exp = 32'd0; end
                4: begin a = 5'd8;  exp = 32'd0; end
                default: begin a = 5'd11; exp = 32'd0; end
            endcase
            bus.address_register = a; bus.address_select = 3'd0;
            #1;
            checks++;
            if (bus.read_data !== exp) begin
                errors++; $display("FAIL reset_read reg%0d got %h want %h", a, bus.read_data, exp);
            end
        end
        checks++;
        if (bus.interrupt_pending !== 1'b0 || bus.exception_level_out !== 1'b0) begin
            errors++; $display("FAIL reset_flags pending %b exl %b want 0 0", bus.interrupt_pending, bus.exception_level_out);
        end
    endtask

    task automatic test_exception();
        bus.exception_valid = 1'b1; bus.exception_address = 32'hBFC0_0100; bus.in_delay_slot = 1'b1;
        bus.exception_code = 5'h04; bus.bad_virtual_address = 32'h3;
        tick();
        bus.exception_valid = 1'b0;
        checks++;
        if (bus.epc_out !== 32'hBFC0_00FC) begin errors++; $display("FAIL exc_epc got %h want bfc000fc", bus.epc_out); end
        bus.address_register = 5'd13; #1;
        checks++;
        if ((bus.read_data & 32'h8000_007C) !== 32'h8000_0010) begin
            errors++; $display("FAIL exc_cause got %h want bd=1 exc=4", bus.read_data);
        end
        bus.address_register = 5'd8; #1;
        checks++;
        if (bus.read_data !== 32'h3) begin errors++; $display("FAIL exc_badvaddr got %h want 3", bus.read_data); end
        checks++;
        if (bus.exception_level_out !== 1'b1) begin errors++; $display("FAIL exc_exl got %b want 1", bus.exception_level_out); end
        // nested exception: EPC/BD hold, ExcCode updates, BadVAddr holds for a non-address code
        bus.exception_valid = 1'b1; bus.exception_address = 32'h0000_1000; bus.in_delay_slot = 1'b0;
        bus.exception_code = 5'h0C; bus.bad_virtual_address = 32'hDEAD_0000;
        tick();
        bus.exception_valid = 1'b0;
        bus.address_register = 5'd13; #1;
        checks++;
        if (bus.epc_out !== 32'hBFC0_00FC || (bus.read_data & 32'h8000_007C) !== 32'h8000_0030) begin
            errors++; $display("FAIL nested_exc epc %h cause %h want bfc000fc bd=1 exc=c", bus.epc_out, bus.read_data);
        end
        bus.address_register = 5'd8; #1;
        checks++;
        if (bus.read_data !== 32'h3) begin errors++; $display("FAIL nested_badvaddr got %h want 3", bus.read_data); end
        bus.eret_flush = 1'b1;
        tick();
        bus.eret_flush = 1'b0;
        checks++;
        if (bus.exception_level_out !== 1'b0) begin errors++; $display("FAIL eret_exl got %b want 0", bus.exception_level_out); end
    endtask

`ifdef CP0_TIMER_EN
    task automatic test_timer();
        mtc0(5'd11, 32'd8);
        mtc0(5'd9, 32'd5);
        repeat (6) tick();
        bus.address_register = 5'd9; #1;
        checks++;
        if (bus.read_data !== 32'd8) begin errors++; $display("FAIL timer_count got %h want 8", bus.read_data); end
        bus.address_register = 5'd13; #1;
        checks++;
        if (bus.read_data[30] !== 1'b0) begin errors++; $display("FAIL timer_ti_early got %b want 0", bus.read_data[30]); end
        tick();
        bus.address_register = 5'd13; #1;
        checks++;
        if (bus.read_data[30] !== 1'b1 || bus.read_data[15] !== 1'b1) begin
            errors++; $display("FAIL timer_ti_set ti %b ip7 %b want 1 1", bus.read_data[30], bus.read_data[15]);
        end
        mtc0(5'd11, 32'h100);
        bus.address_register = 5'd13; #1;
        checks++;
        if (bus.read_data[30] !== 1'b0) begin errors++; $display("FAIL timer_ti_clear got %b want 0", bus.read_data[30]); end
    endtask
`else
    task automatic test_timer_disabled();
        mtc0(5'd9, 32'h55);
        mtc0(5'd11, 32'h55);
        repeat (100) tick();
        bus.address_register = 5'd9; #1;
        checks++;
        if (bus.read_data !== 32'd0) begin errors++; $display("FAIL notimer_count got %h want 0", bus.read_data); end
        bus.address_register = 5'd11; #1;
        checks++;
        if (bus.read_data !== 32'd0) begin errors++; $display("FAIL notimer_compare got %h want 0", bus.read_data); end
        bus.address_register = 5'd13; #1;
        checks++;
        if (bus.read_data[30] !== 1'b0) begin errors++; $display("FAIL notimer_ti got %b want 0", bus.read_data[30]); end
    endtask
`endif

    task automatic test_interrupt();
        bus.hardware_interrupt = '0;
        mtc0(5'd11, 32'hFFFF_FFF0);
        mtc0(5'd12, 32'h0000_FF01);
        checks++;
        if (bus.interrupt_pending !== 1'b0) begin errors++; $display("FAIL irq_idle got %b want 0", bus.interrupt_pending); end
        bus.hardware_interrupt = 6'b000100;
        tick();
        bus.address_register = 5'd13; #1;
        checks++;
        if (bus.read_data[12] !== 1'b1 || bus.interrupt_pending !== 1'b1) begin
            errors++; $display("FAIL irq_hw ip4 %b pending %b want 1 1", bus.read_data[12], bus.interrupt_pending);
        end
        mtc0(5'd12, 32'h0000_FF03);
        checks++;
        if (bus.interrupt_pending !== 1'b0) begin errors++; $display("FAIL irq_exl_mask got %b want 0", bus.interrupt_pending); end
    endtask

    task automatic test_epc_priority();
        mtc0(5'd12, 32'h0);
        bus.write_enabled = 1'b1; bus.address_register = 5'd14; bus.address_select = 3'd0; bus.write_data = 32'h1234;
        bus.exception_valid = 1'b1; bus.exception_address = 32'h8000_0010; bus.in_delay_slot = 1'b0; bus.exception_code = 5'h08;
        tick();
        bus.write_enabled = 1'b0; bus.exception_valid = 1'b0;
        checks++;
        if (bus.epc_out !== 32'h8000_0010) begin errors++; $display("FAIL epc_priority got %h want 80000010", bus.epc_out); end
        bus.eret_flush = 1'b1; tick(); bus.eret_flush = 1'b0;
        mtc0(5'd14, 32'h1234);
        checks++;
        if (bus.epc_out !== 32'h1234) begin errors++; $display("FAIL epc_mtc0 got %h want 1234", bus.epc_out); end
    endtask

    task automatic test_random();
        int unsigned r;
        logic [4:0]  ra;
        logic [2:0]  rs;
        for (int i = 0; i < 500; i++) begin
            reset = ($urandom_range(0, 99) < 2);
            bus.hardware_interrupt = HW'($urandom);
            bus.write_enabled = 1'b0; bus.exception_valid = 1'b0; bus.eret_flush = 1'b0;
            r = $urandom_range(0, 99);
            if (r < 35) begin
                bus.write_enabled = 1'b1;
                bus.address_register = pick_reg();
                bus.address_select = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
                bus.write_data = (bus.address_register == 5'd11 && $urandom_range(0, 1) == 1)
                                 ? m_count() + 32'($urandom_range(0, 6)) : $urandom;
            end else if (r < 50) begin
                bus.exception_valid = 1'b1;
                bus.exception_code = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(4, 5)) : 5'($urandom);
                bus.exception_address = $urandom & 32'hFFFF_FFFC;
                bus.bad_virtual_address = $urandom;
                bus.in_delay_slot = 1'($urandom);
            end else if (r < 60) begin
                bus.eret_flush = 1'b1;
            end
            tick();
            reset = 1'b0; bus.write_enabled = 1'b0; bus.exception_valid = 1'b0; bus.eret_flush = 1'b0;
            ra = pick_reg();
            rs = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            bus.address_register = ra; bus.address_select = rs;
            #1;
            checks++;
            if (bus.read_data !== m_read(ra, rs)) begin
                errors++; $display("FAIL rand_read cyc%0d reg%0d sel%0d got %h want %h", i, ra, rs, bus.read_data, m_read(ra, rs));
            end
            checks++;
            if (bus.epc_out !== m_epc || bus.exception_level_out !== m_exl || bus.interrupt_pending !== m_pending()) begin
                errors++;
                $display("FAIL rand_status cyc%0d epc %h exl %b pend %b want %h %b %b", i, bus.epc_out,
                         bus.exception_level_out, bus.interrupt_pending, m_epc, m_exl, m_pending());
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.write_enabled = 1'b0; bus.address_register = 5'd0; bus.address_select = 3'd0; bus.write_data = 32'd0;
        bus.exception_valid = 1'b0; bus.exception_code = 5'd0; bus.exception_address = 32'd0;
        bus.bad_virtual_address = 32'd0; bus.in_delay_slot = 1'b0; bus.eret_flush = 1'b0; bus.hardware_interrupt = '0;
        #2;
        test_reset();
        test_exception();
`ifdef CP0_TIMER_EN
        test_timer();
`else
        test_timer_disabled();
`endif
        test_interrupt();
        test_epc_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
